word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer_defs.sv | 15 +
 rtl/word_serializer_seg_select.sv | 35 +++
 rtl/word_serializer.sv | 136 +++++++++++++
 tb/tb_word_serializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_defs.sv
// word_serializer_defs
//   Shared definitions for the word serializer slice: FSM state encoding
//   and default word/segment widths. Imported by word_serializer and
//   seg_select.
package word_serializer_defs;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  typedef enum logic {
    IDLE = 1'b0,  // no word held
    SEND = 1'b1   // word held, segments pending
  } state_e;

endpackage

// File: rtl/word_serializer_seg_select.sv
// seg_select
//   Combinational segment multiplexer. Picks segment number idx (in send
//   order) out of word: order=0 counts from the most-significant end,
//   order=1 from the least-significant end.
// Ports
//   word  : in,  WIDTH           held word
//   idx   : in,  clog2(NSEG)     segment position in send order
//   order : in,  1               0 = MSB first, 1 = LSB first
//   seg   : out, SEG             selected segment
module seg_select
  import word_serializer_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic [WIDTH-1:0]              word,
  input  logic [$clog2(WIDTH/SEG)-1:0]  idx,
  input  logic                          order,
  output logic [SEG-1:0]                seg
);

  localparam int NSEG  = WIDTH / SEG;
  localparam int IDX_W = $clog2(NSEG);

  // AND-OR mux over all segment slots; an idx that matches no slot yields
  // zero instead of an out-of-range part-select.
  always_comb begin
    seg = {SEG{1'b0}};
    for (int i = 0; i < NSEG; i++) begin
      seg = seg | ({SEG{idx == IDX_W'(i)}} &
                   (order ? word[SEG*i +: SEG] : word[WIDTH-1-SEG*i -: SEG]));
    end
  end

endmodule

// File: rtl/word_serializer.sv
// word_serializer
//   Splits a WIDTH-bit word into NSEG = WIDTH/SEG segments of SEG bits and
//   streams them out with valid/ready handshakes, MSB-first (order=0) or
//   LSB-first (order=1). A new word can be taken on the same cycle the last
//   segment of the current one is handshaken, giving zero-bubble streaming.
// Ports
//   clk       : in,  1            rising-edge clock
//   reset     : in,  1            synchronous active-high reset
//   in_data   : in,  WIDTH        word to split
//   in_valid  : in,  1            in_data offered
//   in_ready  : out, 1            word accepted this cycle (combinational)
//   order     : in,  1            0 = MSB segment first, 1 = LSB first
//   out_data  : out, SEG          current segment
//   out_valid : out, 1            out_data valid
//   out_ready : in,  1            consumer takes the segment
//   out_idx   : out, clog2(NSEG)  segment position in send order
//   out_last  : out, 1            out_idx == NSEG-1
module word_serializer
  import word_serializer_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          order,
  output logic [SEG-1:0]                out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(WIDTH/SEG)-1:0]  out_idx,
  output logic                          out_last
);

  localparam int                NSEG     = WIDTH / SEG;
  localparam int                IDX_W    = $clog2(NSEG);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NSEG - 1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] word_r;
  logic             order_r;
  logic [IDX_W-1:0] idx_r;
  logic             last_s;
  logic             hs_s;
  logic             accept_s;
  logic             in_ready_s;

  assign last_s   = (idx_r == LAST_IDX);
  // out_valid is exactly "state is SEND", so this is the segment handshake.
  assign hs_s     = (state_r == SEND) & out_ready;
  assign accept_s = in_valid & in_ready_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: leave SEND only after the last segment handshake
  // when no replacement word is taken on that same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (hs_s & last_s & ~accept_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: in_ready is held low while reset is high so nothing is
  // latched on a reset cycle.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s = ~reset;
      SEND:    in_ready_s = ~reset & out_ready & last_s;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Word/order/index datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r  <= {WIDTH{1'b0}};
      order_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      word_r  <= in_data;
      order_r <= order;
      idx_r   <= {IDX_W{1'b0}};
    end else if (hs_s) begin
      // Wrap to 0 after the last segment so IDLE reports index 0.
      if (last_s) begin
        idx_r <= {IDX_W{1'b0}};
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  seg_select #(
    .WIDTH (WIDTH),
    .SEG   (SEG)
  ) u_seg_select (
    .word  (word_r),
    .idx   (idx_r),
    .order (order_r),
    .seg   (out_data)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == SEND);
  assign out_idx   = idx_r;
  assign out_last  = last_s;

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer
//   Self-checking bench for word_serializer: a 32/8 instance for most
//   scenarios and a 16/4 instance for the narrow configuration. Expected
//   segments come from a shift/mask model of the segment ordering rules.
module tb_word_serializer;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        order;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_idx;
  logic        out_last;

  logic [15:0] n_in_data;
  logic        n_in_valid;
  logic        n_in_ready;
  logic        n_order;
  logic [3:0]  n_out_data;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [1:0]  n_out_idx;
  logic        n_out_last;

  int n_cmp;
  int n_err;

  word_serializer #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .order(order), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last)
  );

  word_serializer #(.WIDTH(16), .SEG(4)) dut_n (
    .clk(clk), .reset(reset), .in_data(n_in_data), .in_valid(n_in_valid),
    .in_ready(n_in_ready), .order(n_order), .out_data(n_out_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_idx(n_out_idx),
    .out_last(n_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment k in send order: order=0 counts from the top of the word.
  function automatic logic [31:0] model_seg(input logic [31:0] w, input logic ord,
                                            input int k, input int width, input int seg);
    int sh;
    sh = ord ? seg * k : width - seg * (k + 1);
    return (w >> sh) & ((32'd1 << seg) - 32'd1);
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = $urandom; order = 1'b0; out_ready = 1'b1;
    n_in_valid = 1'b1; n_in_data = 16'($urandom); n_order = 1'b0; n_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_cmp++; if (out_idx !== 2'd0) begin n_err++; $display("FAIL rst_idx got %0d want 0", out_idx); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_data got %h want 00", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (n_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_n_valid got %b want 0", n_out_valid); end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; n_in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_serialize();
    logic [31:0] words [8];
    logic        ords  [8];
    logic [7:0]  exp_s;
    words[0] = 32'h000003E8; ords[0] = 1'b0;
    words[1] = 32'h12345678; ords[1] = 1'b1;
    for (int j = 2; j < 8; j++) begin words[j] = $urandom; ords[j] = 1'($urandom); end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      in_data = words[j]; order = ords[j]; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ser_accept w%0d got %b want 1", j, in_ready); end
      @(posedge clk); #1;
      // Scramble inputs: they must not affect the word in flight.
      in_valid = 1'b0; in_data = $urandom; order = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
        exp_s = 8'(model_seg(words[j], ords[j], k, 32, 8));
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ser_valid w%0d k%0d got %b want 1", j, k, out_valid); end
        n_cmp++; if (out_data !== exp_s) begin n_err++; $display("FAIL ser_data w%0d k%0d got %h want %h", j, k, out_data, exp_s); end
        n_cmp++; if (out_idx !== 2'(k)) begin n_err++; $display("FAIL ser_idx w%0d got %0d want %0d", j, out_idx, k); end
        n_cmp++; if (out_last !== (k == 3)) begin n_err++; $display("FAIL ser_last w%0d k%0d got %b", j, k, out_last); end
        @(posedge clk); #1;
      end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ser_idle w%0d got %b want 0", j, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [2];
    logic        ords  [2];
    int          at    [2];
    int          len   [2];
    logic [7:0]  exp_s;
    words[0] = 32'hAABBCCDD; ords[0] = 1'b0; at[0] = 1; len[0] = 3;
    words[1] = $urandom; ords[1] = 1'($urandom); at[1] = $urandom_range(0, 3); len[1] = $urandom_range(1, 5);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      in_data = words[j]; order = ords[j]; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = $urandom;
      for (int k = 0; k < 4; k++) begin
        exp_s = 8'(model_seg(words[j], ords[j], k, 32, 8));
        if (k == at[j]) begin
          out_ready = 1'b0;
          for (int s = 0; s < len[j]; s++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid w%0d s%0d got %b want 1", j, s, out_valid); end
            n_cmp++; if (out_data !== exp_s) begin n_err++; $display("FAIL bp_hold w%0d s%0d got %h want %h", j, s, out_data, exp_s); end
            n_cmp++; if (out_idx !== 2'(k)) begin n_err++; $display("FAIL bp_idx w%0d got %0d want %0d", j, out_idx, k); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready w%0d got %b want 0", j, in_ready); end
            @(posedge clk); #1;
          end
          out_ready = 1'b1;
        end
        n_cmp++; if (out_data !== exp_s) begin n_err++; $display("FAIL bp_data w%0d k%0d got %h want %h", j, k, out_data, exp_s); end
        n_cmp++; if (out_idx !== 2'(k)) begin n_err++; $display("FAIL bp_idx2 w%0d got %0d want %0d", j, out_idx, k); end
        @(posedge clk); #1;
      end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle w%0d got %b want 0", j, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [5];
    logic        ords  [5];
    logic [7:0]  exp_s;
    words[0] = 32'h11223344; ords[0] = 1'b0;
    words[1] = 32'h55667788; ords[1] = 1'b0;
    for (int j = 2; j < 5; j++) begin words[j] = $urandom; ords[j] = 1'($urandom); end
    @(negedge clk);
    in_data = words[0]; order = ords[0]; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 4; k++) begin
        exp_s = 8'(model_seg(words[j], ords[j], k, 32, 8));
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid w%0d k%0d got %b want 1", j, k, out_valid); end
        n_cmp++; if (out_data !== exp_s) begin n_err++; $display("FAIL b2b_data w%0d k%0d got %h want %h", j, k, out_data, exp_s); end
        n_cmp++; if (out_idx !== 2'(k)) begin n_err++; $display("FAIL b2b_idx w%0d got %0d want %0d", j, out_idx, k); end
        if (k < 3) begin
          in_data = $urandom; order = 1'($urandom);
        end else if (j < 4) begin
          in_data = words[j+1]; order = ords[j+1];
          #1;
          n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready w%0d got %b want 1", j, in_ready); end
        end else begin
          in_valid = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_s;
    @(negedge clk);
    in_data = 32'hDEADBEEF; order = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_s = 8'(model_seg(32'hDEADBEEF, 1'b0, k, 32, 8));
      n_cmp++; if (out_data !== exp_s) begin n_err++; $display("FAIL rm_data k%0d got %h want %h", k, out_data, exp_s); end
      if (k < 2) begin @(posedge clk); #1; end
    end
    // Reset at idx 2 while a new word is also offered: nothing may be taken.
    reset = 1'b1; in_valid = 1'b1; in_data = $urandom;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rm_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b want 0", out_valid); end
    n_cmp++; if (out_idx !== 2'd0) begin n_err++; $display("FAIL rm_idx got %0d want 0", out_idx); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rm_data_clr got %h want 00", out_data); end
    reset = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_no_emit c%0d got valid %b data %h want valid 0", c, out_valid, out_data); end
    end
  endtask

  task automatic test_narrow();
    logic [15:0] words [5];
    logic        ords  [5];
    logic [3:0]  exp_s;
    words[0] = 16'hA5C3; ords[0] = 1'b0;
    for (int j = 1; j < 5; j++) begin words[j] = 16'($urandom); ords[j] = 1'($urandom); end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_in_data = words[j]; n_order = ords[j]; n_in_valid = 1'b1; n_out_ready = 1'b1;
      @(posedge clk); #1;
      n_in_valid = 1'b0; n_in_data = 16'($urandom); n_order = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
        exp_s = 4'(model_seg({16'h0000, words[j]}, ords[j], k, 16, 4));
        n_cmp++; if (n_out_valid !== 1'b1) begin n_err++; $display("FAIL nar_valid w%0d k%0d got %b want 1", j, k, n_out_valid); end
        n_cmp++; if (n_out_data !== exp_s) begin n_err++; $display("FAIL nar_data w%0d k%0d got %h want %h", j, k, n_out_data, exp_s); end
        n_cmp++; if (n_out_idx !== 2'(k)) begin n_err++; $display("FAIL nar_idx w%0d got %0d want %0d", j, n_out_idx, k); end
        n_cmp++; if (n_out_last !== (k == 3)) begin n_err++; $display("FAIL nar_last w%0d k%0d got %b", j, k, n_out_last); end
        @(posedge clk); #1;
      end
      n_cmp++; if (n_out_valid !== 1'b0) begin n_err++; $display("FAIL nar_idle w%0d got %b want 0", j, n_out_valid); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_serialize();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
